// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: miss-handling sequencer for a direct-mapped write-back
// data cache. Hits complete in the lookup cycle. A miss optionally evicts a
// dirty victim, refills the line and rewrites the tag, then re-looks-up and hits.
module cache_miss_ctrl #(
    parameter int unsigned TAG_W    = 21,
    parameter int unsigned INDEX_W  = 6,
    parameter int unsigned OFFSET_W = 5,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [31:0]        cpu_addr,
    output logic               cpu_ready,
    output logic               cpu_stall,
    output logic [INDEX_W-1:0] tag_index,
    input  logic               tag_rd_valid,
    input  logic               tag_rd_dirty,
    input  logic [TAG_W-1:0]   tag_rd_tag,
    output logic               tag_we,
    output logic               tag_wr_valid,
    output logic               tag_wr_dirty,
    output logic [TAG_W-1:0]   tag_wr_tag,
    output logic               wb_start,
    output logic [31:0]        wb_addr,
    input  logic               wb_done,
    output logic               fill_start,
    output logic [31:0]        fill_addr,
    input  logic               fill_done,
    output logic [CNT_W-1:0]   miss_count,
    output logic [CNT_W-1:0]   wb_count
);

    localparam int unsigned IDX_LO = OFFSET_W;
    localparam int unsigned IDX_HI = OFFSET_W + INDEX_W - 1;
    localparam int unsigned TAG_LO = OFFSET_W + INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_REQ,
        S_WB_WAIT,
        S_FILL_REQ,
        S_FILL_WAIT,
        S_UPDATE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_req_addr;
    logic [TAG_W-1:0]   r_victim_tag;
    logic               r_wb_start;
    logic               r_fill_start;
    logic [31:0]        r_wb_addr;
    logic [31:0]        r_fill_addr;
    logic [CNT_W-1:0]   r_miss_count;
    logic [CNT_W-1:0]   r_wb_count;
    logic               w_hit;
    logic               w_miss;
    logic               w_dirty_victim;

    assign w_hit          = tag_rd_valid && (tag_rd_tag == cpu_addr[31:TAG_LO]);
    assign w_miss         = (r_state == S_IDLE) && cpu_req && !w_hit;
    assign w_dirty_victim = tag_rd_valid && tag_rd_dirty;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_miss) w_next = w_dirty_victim ? S_WB_REQ : S_FILL_REQ;
            S_WB_REQ:    w_next = S_WB_WAIT;
            S_WB_WAIT:   if (wb_done) w_next = S_FILL_REQ;
            S_FILL_REQ:  w_next = S_FILL_WAIT;
            S_FILL_WAIT: if (fill_done) w_next = S_UPDATE;
            S_UPDATE:    w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Request latch, registered engine starts/addresses and saturating counters.
    // Start pulses are the registered decode of the REQ states, so each engine
    // sees a single-cycle level with its address already stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_addr   <= '0;
            r_victim_tag <= '0;
            r_wb_start   <= 1'b0;
            r_fill_start <= 1'b0;
            r_wb_addr    <= '0;
            r_fill_addr  <= '0;
            r_miss_count <= '0;
            r_wb_count   <= '0;
        end else begin
            r_wb_start   <= (r_state == S_WB_REQ);
            r_fill_start <= (r_state == S_FILL_REQ);
            if (w_miss) begin
                r_req_addr   <= cpu_addr;
                r_victim_tag <= tag_rd_tag;
                if (r_miss_count != '1) r_miss_count <= r_miss_count + CNT_W'(1);
                if (w_dirty_victim && (r_wb_count != '1)) r_wb_count <= r_wb_count + CNT_W'(1);
            end
            if (r_state == S_WB_REQ)
                r_wb_addr <= {r_victim_tag, r_req_addr[IDX_HI:IDX_LO], {OFFSET_W{1'b0}}};
            if (r_state == S_FILL_REQ)
                r_fill_addr <= {r_req_addr[31:TAG_LO], r_req_addr[IDX_HI:IDX_LO], {OFFSET_W{1'b0}}};
        end
    end

    // Output decode: hit completion, tag index and tag-store writes
    always_comb begin
        cpu_ready    = 1'b0;
        tag_we       = 1'b0;
        tag_wr_valid = 1'b0;
        tag_wr_dirty = 1'b0;
        tag_wr_tag   = '0;
        tag_index    = r_req_addr[IDX_HI:IDX_LO];
        case (r_state)
            S_IDLE: begin
                tag_index = cpu_addr[IDX_HI:IDX_LO];
                if (cpu_req && w_hit) begin
                    cpu_ready = 1'b1;
                    if (cpu_we) begin
                        tag_we       = 1'b1;
                        tag_wr_valid = 1'b1;
                        tag_wr_dirty = 1'b1;
                        tag_wr_tag   = tag_rd_tag;
                    end
                end
            end
            S_UPDATE: begin
                tag_we       = 1'b1;
                tag_wr_valid = 1'b1;
                tag_wr_dirty = 1'b0;
                tag_wr_tag   = r_req_addr[31:TAG_LO];
            end
            default: ;
        endcase
    end

    assign cpu_stall  = cpu_req && !cpu_ready;
    assign wb_start   = r_wb_start;
    assign fill_start = r_fill_start;
    assign wb_addr    = r_wb_addr;
    assign fill_addr  = r_fill_addr;
    assign miss_count = r_miss_count;
    assign wb_count   = r_wb_count;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb_cache_miss_ctrl: scoreboard bench with a tag-store model, behavioural
// line-transfer engines and a cache-level reference model.
module tb_cache_miss_ctrl;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic cpu_ready, cpu_stall;
    logic [5:0] tag_index;
    logic tag_rd_valid, tag_rd_dirty;
    logic [20:0] tag_rd_tag;
    logic tag_we, tag_wr_valid, tag_wr_dirty;
    logic [20:0] tag_wr_tag;
    logic wb_start, wb_done, fill_start, fill_done;
    logic [31:0] wb_addr, fill_addr;
    logic [CNT_W-1:0] miss_count, wb_count;

    logic wb_done_eng = 1'b0, fill_done_eng = 1'b0;
    logic spur_fill_w = 1'b0, spur_fill_d = 1'b0, spur_wb = 1'b0;
    assign wb_done   = wb_done_eng | spur_wb;
    assign fill_done = fill_done_eng | spur_fill_w | spur_fill_d;

    cache_miss_ctrl #(.TAG_W(21), .INDEX_W(6), .OFFSET_W(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready), .cpu_stall(cpu_stall), .tag_index(tag_index),
        .tag_rd_valid(tag_rd_valid), .tag_rd_dirty(tag_rd_dirty), .tag_rd_tag(tag_rd_tag),
        .tag_we(tag_we), .tag_wr_valid(tag_wr_valid), .tag_wr_dirty(tag_wr_dirty),
        .tag_wr_tag(tag_wr_tag), .wb_start(wb_start), .wb_addr(wb_addr), .wb_done(wb_done),
        .fill_start(fill_start), .fill_addr(fill_addr), .fill_done(fill_done),
        .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic finish_sim();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    // Tag store environment (combinational read, write at clock edge)
    logic        mem_valid [64];
    logic        mem_dirty [64];
    logic [20:0] mem_tag   [64];
    logic        init_mem = 1'b0;
    assign tag_rd_valid = mem_valid[tag_index];
    assign tag_rd_dirty = mem_dirty[tag_index];
    assign tag_rd_tag   = mem_tag[tag_index];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) begin
                mem_valid[i] <= 1'b0;
                mem_dirty[i] <= 1'b1;   // invalid-but-dirty lines must not be written back
                mem_tag[i]   <= 21'($urandom);
            end
        end else if (tag_we) begin
            mem_valid[tag_index] <= tag_wr_valid;
            mem_dirty[tag_index] <= tag_wr_dirty;
            mem_tag[tag_index]   <= tag_wr_tag;
        end
    end

    // Engine latencies and spurious-done mode, set by the driver per access
    int wb_lat = 1, fill_lat = 1;
    bit spur_mode = 0;

    // Writeback engine: done wb_lat cycles after start; optional spurious fill_done
    always begin
        @(negedge clk);
        if (wb_start && !rst) begin
            automatic int lat = wb_lat;
            automatic logic [31:0] a = wb_addr;
            automatic bit ab = 0;
            for (int i = 0; i < lat; i++) begin
                @(posedge clk);
                if (rst) begin ab = 1; break; end
                #1 spur_fill_w = spur_mode && (i == 0 || i == lat - 1);
            end
            if (ab) spur_fill_w = 1'b0;
            else begin
                wb_done_eng = 1'b1;
                check("wb_addr_stable", wb_addr, a);
                @(posedge clk);
                #1 wb_done_eng = 1'b0;
                spur_fill_w = 1'b0;
            end
        end
    end

    // Fill engine: done fill_lat cycles after start, aborted by reset
    always begin
        @(negedge clk);
        if (fill_start && !rst) begin
            automatic int lat = fill_lat;
            automatic logic [31:0] a = fill_addr;
            automatic bit ab = 0;
            for (int i = 0; i < lat; i++) begin
                @(posedge clk);
                if (rst) begin ab = 1; break; end
            end
            if (!ab) begin
                #1 fill_done_eng = 1'b1;
                check("fill_addr_stable", fill_addr, a);
                @(posedge clk);
                #1 fill_done_eng = 1'b0;
            end
        end
    end

    // Scoreboard queues
    logic [63:0] exp_wb[$];
    logic [63:0] exp_fill[$];
    logic [63:0] exp_tw[$];
    int          exp_lat[$];

    // Monitor: compares every DUT event against the head of its queue
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_start) begin
                if (exp_wb.size() == 0) check("unexpected_wb_start", 1, 0);
                else check("wb_addr", wb_addr, exp_wb.pop_front());
            end
            if (fill_start) begin
                if (exp_fill.size() == 0) check("unexpected_fill_start", 1, 0);
                else check("fill_addr", fill_addr, exp_fill.pop_front());
            end
            if (tag_we) begin
                if (exp_tw.size() == 0) check("unexpected_tag_we", 1, 0);
                else check("tag_write", {tag_index, tag_wr_valid, tag_wr_dirty, tag_wr_tag},
                           exp_tw.pop_front());
            end
            if (cpu_ready) begin
                if (exp_lat.size() == 0) check("unexpected_cpu_ready", 1, 0);
                else check("latency", cyc - start_cyc, exp_lat.pop_front());
                check("stall_at_ready", cpu_stall, 0);
            end
        end
    end

    // Reference cache model
    bit        m_valid [64];
    bit        m_dirty [64];
    bit [20:0] m_tag   [64];
    int        m_miss = 0, m_wb = 0;

    task automatic model_access(input logic [31:0] a, input logic we, input int wl, input int fl,
                                input bit completes, input bit installs, output int lat);
        automatic int idx = int'(a[10:5]);
        automatic logic [20:0] tg = a[31:11];
        if (m_valid[idx] && m_tag[idx] == tg) begin
            lat = 0;
            if (we && completes) begin
                m_dirty[idx] = 1;
                exp_tw.push_back({6'(idx), 1'b1, 1'b1, tg});
            end
        end else begin
            if (m_miss < CMAX) m_miss++;
            if (m_valid[idx] && m_dirty[idx]) begin
                exp_wb.push_back({m_tag[idx], 6'(idx), 5'b0});
                if (m_wb < CMAX) m_wb++;
                lat = wl + fl + 6;
            end else lat = fl + 4;
            exp_fill.push_back({tg, 6'(idx), 5'b0});
            if (installs) begin
                exp_tw.push_back({6'(idx), 1'b1, 1'b0, tg});
                m_valid[idx] = 1; m_tag[idx] = tg; m_dirty[idx] = 0;
                if (we && completes) begin
                    m_dirty[idx] = 1;
                    exp_tw.push_back({6'(idx), 1'b1, 1'b1, tg});
                end
            end
        end
    endtask

    task automatic access(input logic [31:0] a, input logic we, input int wl, input int fl,
                          input bit sm);
        int lat;
        bit got;
        model_access(a, we, wl, fl, 1, 1, lat);
        exp_lat.push_back(lat);
        wb_lat = wl; fill_lat = fl; spur_mode = sm;
        @(posedge clk);
        #1 cpu_req = 1'b1; cpu_we = we; cpu_addr = a; start_cyc = cyc;
        got = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (cpu_ready) begin got = 1; break; end
        end
        if (!got) begin
            check("ready_timeout", 0, 1);
            finish_sim();
        end
        check("miss_count", miss_count, m_miss);
        check("wb_count", wb_count, m_wb);
        @(posedge clk);
        #1 cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = $urandom;
    endtask

    initial begin
        #500000;
        check("global_timeout", 0, 1);
        finish_sim();
    end

    initial begin
        int lat;
        bit got;
        logic [31:0] a;
        for (int i = 0; i < 64; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; end
        rst = 1'b1; init_mem = 1'b1;
        repeat (2) @(posedge clk);
        #1 init_mem = 1'b0;
        @(negedge clk);
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_tag_we", tag_we, 0);
        check("rst_wb_start", wb_start, 0);
        check("rst_fill_start", fill_start, 0);
        check("rst_addrs", {wb_addr, fill_addr}, 0);
        check("rst_counts", {miss_count, wb_count}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Cold read, write hit, dirty eviction with spurious/simultaneous fill_done
        access(32'h0000_1040, 1'b0, 2, 3, 0);
        access(32'h0000_1044, 1'b1, 2, 3, 0);
        access(32'h0000_3040, 1'b0, 4, 2, 1);

        // Spurious done pulses in IDLE must be ignored
        @(posedge clk);
        #1 spur_wb = 1'b1; spur_fill_d = 1'b1;
        @(posedge clk);
        #1 spur_wb = 1'b0; spur_fill_d = 1'b0;
        repeat (3) @(posedge clk);
        access(32'h0000_3048, 1'b0, 1, 1, 0);

        // Randomized mix of hits, clean misses and dirty evictions
        for (int n = 0; n < 150; n++) begin
            a = {19'($urandom_range(0, 3)), 2'b00, 6'($urandom_range(0, 5)), 5'($urandom)};
            access(a, 1'($urandom), $urandom_range(1, 5), $urandom_range(1, 5),
                   ($urandom_range(0, 3) == 0));
        end

        // Request dropped mid-miss: line installed, nothing completes
        a = {m_tag[9] + 21'd1, 6'd9, 5'd4};
        model_access(a, 1'b1, 3, 3, 0, 1, lat);
        wb_lat = 3; fill_lat = 3; spur_mode = 0;
        @(posedge clk);
        #1 cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a;
        @(posedge clk);
        #1 cpu_req = 1'b0; cpu_addr = $urandom;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("drop_miss_count", miss_count, m_miss);
        access(a, 1'b0, 1, 1, 0);

        // Reset during FILL_WAIT: aborted, next access to the same line misses again
        a = {m_tag[12] + 21'd5, 6'd12, 5'd0};
        model_access(a, 1'b0, 2, 20, 0, 0, lat);
        wb_lat = 2; fill_lat = 20; spur_mode = 0;
        @(posedge clk);
        #1 cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        got = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (fill_start) begin got = 1; break; end
        end
        if (!got) begin
            check("fill_start_timeout", 0, 1);
            finish_sim();
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1; cpu_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        m_miss = 0; m_wb = 0;
        @(negedge clk);
        check("rstmid_outputs",
              {cpu_ready, cpu_stall, tag_we, wb_start, fill_start}, 0);
        check("rstmid_addrs", {wb_addr, fill_addr}, 0);
        check("rstmid_counts", {miss_count, wb_count}, 0);
        access(a, 1'b0, 1, 2, 0);

        // Saturation of the miss counter
        for (int n = 0; n < CMAX + 6; n++)
            access({21'h100 + 21'(n % 2), 6'd20, 5'd0}, 1'b0, 1, 1, 0);
        check("miss_count_saturated", miss_count, CMAX);

        repeat (3) @(posedge clk);
        check("queues_drained", exp_wb.size() + exp_fill.size() + exp_tw.size() + exp_lat.size(), 0);
        finish_sim();
    end

endmodule
